// File: rtl/ui_pkg.sv
// ---------------------------------------------------------------------------
// ui_pkg
// Shared board/UI definitions. Used by the player mover, the sprite renderer
// and the button test top.
//   mover_state_t : player mover FSM states
//   START_X       : home x position of every token (pixels)
//   TILE_SPACING  : pixels between tile origins
//   MAX_X         : x of the flag tile, the largest legal move target
// ---------------------------------------------------------------------------
package ui_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_LAND,
        ST_DONE,
        ST_REARM
    } mover_state_t;

    localparam int unsigned START_X      = 20;
    localparam int unsigned TILE_SPACING = 60;
    localparam int unsigned MAX_X        = 620;

endpackage

// File: rtl/player_mover_if.sv
// ---------------------------------------------------------------------------
// player_mover_if
// Move handshake between the game/test controller (master) and a player
// mover (slave).
//   move_start : level request, held by the master until it sees turn_done
//   target_x   : destination x, sampled by the slave only at accept
//   turn_done  : one-cycle completion pulse from the slave
//   move_err   : high with turn_done when the request was rejected
//   busy       : slave is animating (MOVE or LAND)
// ---------------------------------------------------------------------------
interface player_mover_if;

    logic       move_start;
    logic [9:0] target_x;
    logic       turn_done;
    logic       move_err;
    logic       busy;

    modport master (
        output move_start, target_x,
        input  turn_done, move_err, busy
    );

    modport slave (
        input  move_start, target_x,
        output turn_done, move_err, busy
    );

endinterface

// File: rtl/player_mover_hop_arc.sv
// ---------------------------------------------------------------------------
// hop_arc
// Registered hop height for the token: a parabola over one tile,
// hop_y = (d * (TILE_SPACING - d)) >> HOP_SHIFT while active, else 0.
//   clk_100mhz, btn_reset : clock, async active-high reset
//   active                : token is hopping in the coming cycle
//   d                     : sub-tile offset the FSM is about to register
//   hop_y                 : upward sprite offset in pixels
// Fed with the FSM's next d so hop_y changes on the same edge as d.
// ---------------------------------------------------------------------------
module hop_arc #(
    parameter int unsigned TILE_SPACING = 60,
    parameter int unsigned HOP_SHIFT    = 4,
    parameter int unsigned DW           = 7
) (
    input  logic          clk_100mhz,
    input  logic          btn_reset,
    input  logic          active,
    input  logic [DW-1:0] d,
    output logic [5:0]    hop_y
);

    logic [11:0] prod;

    always_comb begin
        prod = 12'(d) * (12'(TILE_SPACING) - 12'(d));
    end

    always_ff @(posedge clk_100mhz or posedge btn_reset) begin
        if (btn_reset) begin
            hop_y <= '0;
        end else begin
            hop_y <= active ? 6'(prod >> HOP_SHIFT) : '0;
        end
    end

endmodule

// File: rtl/player_mover.sv
// ---------------------------------------------------------------------------
// player_mover
// Responder end of the player move handshake. Accepts a tile-aligned target
// column, walks the token there STEP_PX pixels per frame tick with a hop arc
// per tile, holds LAND_FRAMES ticks, then pulses turn_done. Illegal targets
// are answered at once with turn_done + move_err and no motion.
//   clk_100mhz, btn_reset : clock, async active-high reset (aborts a move)
//   frame_tick            : one-cycle pulse per video frame
//   mv (slave)            : move_start/target_x in, turn_done/move_err/busy out
//   pos_x, hop_y, tile_idx: token position for the sprite renderer
// ---------------------------------------------------------------------------
module player_mover #(
    parameter int unsigned START_X      = ui_pkg::START_X,
    parameter int unsigned TILE_SPACING = ui_pkg::TILE_SPACING,
    parameter int unsigned MAX_X        = ui_pkg::MAX_X,
    parameter int unsigned STEP_PX      = 2,
    parameter int unsigned LAND_FRAMES  = 4,
    parameter int unsigned HOP_SHIFT    = 4
) (
    input  logic          clk_100mhz,
    input  logic          btn_reset,
    input  logic          frame_tick,
    player_mover_if.slave mv,
    output logic [9:0]    pos_x,
    output logic [5:0]    hop_y,
    output logic [3:0]    tile_idx
);

    import ui_pkg::*;

    localparam int unsigned DW = $clog2(2 * TILE_SPACING);
    localparam int unsigned LW = $clog2(LAND_FRAMES + 1);

    mover_state_t  state;
    logic [9:0]    target;
    logic [DW-1:0] d;
    logic [DW-1:0] d_nxt;
    logic [DW-1:0] d_sum;
    logic [LW-1:0] land_cnt;
    logic          err_flag;
    logic [10:0]   pos_sum;
    logic          arrive;
    logic          tile_wrap;
    logic          req_bad;
    logic          hop_active;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pos_sum    = {1'b0, pos_x} + 11'(STEP_PX);
        arrive     = pos_sum >= {1'b0, target};
        d_sum      = d + DW'(STEP_PX);
        tile_wrap  = d_sum >= DW'(TILE_SPACING);
        // target_x <= pos_x also covers targets left of home, so the wrapped
        // subtraction in the alignment test never decides alone.
        req_bad    = (mv.target_x <= pos_x) ||
                     (mv.target_x > 10'(MAX_X)) ||
                     (((mv.target_x - 10'(START_X)) % 10'(TILE_SPACING)) != '0);
        d_nxt      = d;
        hop_active = 1'b0;
        if (state == ST_MOVE) begin
            hop_active = 1'b1;
            if (frame_tick) begin
                if (arrive) begin
                    d_nxt      = '0;
                    hop_active = 1'b0;
                end else begin
                    d_nxt = tile_wrap ? d_sum - DW'(TILE_SPACING) : d_sum;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and ordering between blocks is moot.
    always_ff @(posedge clk_100mhz or posedge btn_reset) begin
        if (btn_reset) begin
            state        <= ST_IDLE;
            pos_x        <= 10'(START_X);
            tile_idx     <= '0;
            target       <= 10'(START_X);
            d            <= '0;
            land_cnt     <= '0;
            err_flag     <= 1'b0;
            mv.busy      <= 1'b0;
            mv.turn_done <= 1'b0;
            mv.move_err  <= 1'b0;
        end else begin
            mv.turn_done <= 1'b0;
            mv.move_err  <= 1'b0;
            d            <= d_nxt;
            case (state)
                ST_IDLE: begin
                    // A frame_tick in the accept cycle is ignored here, so it
                    // never advances the new move.
                    if (mv.move_start) begin
                        target   <= mv.target_x;
                        err_flag <= req_bad;
                        if (req_bad) begin
                            state        <= ST_DONE;
                            mv.turn_done <= 1'b1;
                            mv.move_err  <= 1'b1;
                        end else begin
                            state   <= ST_MOVE;
                            mv.busy <= 1'b1;
                        end
                    end
                end
                ST_MOVE: begin
                    if (frame_tick) begin
                        if (arrive) begin
                            pos_x    <= target;
                            tile_idx <= 4'((target - 10'(START_X)) / 10'(TILE_SPACING));
                            land_cnt <= '0;
                            state    <= ST_LAND;
                        end else begin
                            pos_x <= pos_sum[9:0];
                            if (tile_wrap) begin
                                tile_idx <= tile_idx + 4'd1;
                            end
                        end
                    end
                end
                ST_LAND: begin
                    if (frame_tick) begin
                        if (land_cnt == LW'(LAND_FRAMES - 1)) begin
                            state        <= ST_DONE;
                            mv.busy      <= 1'b0;
                            mv.turn_done <= 1'b1;
                            mv.move_err  <= err_flag;
                        end else begin
                            land_cnt <= land_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_REARM;
                end
                ST_REARM: begin
                    // A request still held from the last turn must be
                    // released before another is accepted.
                    if (!mv.move_start) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    hop_arc #(
        .TILE_SPACING (TILE_SPACING),
        .HOP_SHIFT    (HOP_SHIFT),
        .DW           (DW)
    ) u_hop_arc (
        .clk_100mhz (clk_100mhz),
        .btn_reset  (btn_reset),
        .active     (hop_active),
        .d          (d_nxt),
        .hop_y      (hop_y)
    );

endmodule

// File: tb/tb_player_mover.sv
// ---------------------------------------------------------------------------
// tb_player_mover
// Self-checking bench for player_mover. Directed steps followed by random
// moves; expected values come from a model of the token's path written as
// plain arithmetic on pixel positions.
// ---------------------------------------------------------------------------
module tb_player_mover;

    localparam int START_X = 20;
    localparam int SP      = 60;
    localparam int MAX_X   = 620;
    localparam int STEP    = 2;
    localparam int LAND    = 4;
    localparam int HSH     = 4;

    logic       clk_100mhz = 1'b0;
    logic       btn_reset;
    logic       frame_tick;
    logic [9:0] pos_x;
    logic [5:0] hop_y;
    logic [3:0] tile_idx;

    player_mover_if mv ();

    player_mover #(
        .START_X      (START_X),
        .TILE_SPACING (SP),
        .MAX_X        (MAX_X),
        .STEP_PX      (STEP),
        .LAND_FRAMES  (LAND),
        .HOP_SHIFT    (HSH)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .btn_reset  (btn_reset),
        .frame_tick (frame_tick),
        .mv         (mv.slave),
        .pos_x      (pos_x),
        .hop_y      (hop_y),
        .tile_idx   (tile_idx)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int errors = 0;
    int checks = 0;
    int model_pos;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit req_valid(input int pos, input int tgt);
        return !(tgt <= pos || tgt > MAX_X || ((tgt - START_X) % SP) != 0);
    endfunction

    function automatic int exp_hop(input int p, input bit moving);
        int d;
        d = (p - START_X) % SP;
        return moving ? (d * (SP - d)) >> HSH : 0;
    endfunction

    // One frame tick; returns right after the following negedge.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk_100mhz);
        frame_tick = 1'b0;
    endtask

    // Issue a request from the current model position and follow it to the
    // end of the turn. Called and returns just after a negedge.
    task automatic run_move(input int tgt, input int drop_at, input bit hold_after,
                            input bit tick_at_accept);
        int start;
        int n_ticks;
        int p;
        start         = model_pos;
        mv.move_start = 1'b1;
        mv.target_x   = 10'(tgt);
        frame_tick    = tick_at_accept;
        @(negedge clk_100mhz);
        frame_tick = 1'b0;
        if (!req_valid(start, tgt)) begin
            check("rej_done", mv.turn_done, 1);
            check("rej_err", mv.move_err, 1);
            check("rej_busy", mv.busy, 0);
            check("rej_pos", pos_x, start);
            if (!hold_after) mv.move_start = 1'b0;
            @(negedge clk_100mhz);
            check("rej_pulse_width", mv.turn_done, 0);
            check("rej_busy_after", mv.busy, 0);
            if (!hold_after) @(negedge clk_100mhz);
            return;
        end
        check("acc_busy", mv.busy, 1);
        check("acc_done", mv.turn_done, 0);
        check("acc_pos", pos_x, start);
        mv.target_x = 10'($urandom_range(0, 1023));
        n_ticks = (tgt - start + STEP - 1) / STEP;
        for (int n = 1; n <= n_ticks; n++) begin
            @(negedge clk_100mhz);
            tick();
            if (n == drop_at) mv.move_start = 1'b0;
            p = (start + n * STEP < tgt) ? start + n * STEP : tgt;
            check("mv_pos", pos_x, p);
            check("mv_tile", tile_idx, (p - START_X) / SP);
            check("mv_hop", hop_y, exp_hop(p, p < tgt));
            check("mv_busy", mv.busy, 1);
            check("mv_done", mv.turn_done, 0);
            if (start == 20 && tgt == 80 && n == 15) begin
                check("mid_pos", pos_x, 50);
                check("mid_hop", hop_y, 56);
            end
        end
        for (int n = 1; n <= LAND; n++) begin
            @(negedge clk_100mhz);
            tick();
            if (n < LAND) begin
                check("land_busy", mv.busy, 1);
                check("land_done", mv.turn_done, 0);
                check("land_hop", hop_y, 0);
                check("land_pos", pos_x, tgt);
            end else begin
                check("fin_done", mv.turn_done, 1);
                check("fin_err", mv.move_err, 0);
                check("fin_busy", mv.busy, 0);
                check("fin_pos", pos_x, tgt);
                check("fin_tile", tile_idx, (tgt - START_X) / SP);
                check("fin_hop", hop_y, 0);
            end
        end
        model_pos = tgt;
        if (!hold_after) mv.move_start = 1'b0;
        @(negedge clk_100mhz);
        check("fin_pulse_width", mv.turn_done, 0);
        if (!hold_after) @(negedge clk_100mhz);
    endtask

    initial begin
        int pulses;
        int r;
        int tgt;
        int rem;
        btn_reset     = 1'b1;
        frame_tick    = 1'b0;
        mv.move_start = 1'b0;
        mv.target_x   = '0;
        model_pos     = START_X;
        repeat (3) @(negedge clk_100mhz);
        check("rst_pos", pos_x, START_X);
        check("rst_tile", tile_idx, 0);
        check("rst_hop", hop_y, 0);
        check("rst_busy", mv.busy, 0);
        check("rst_done", mv.turn_done, 0);
        check("rst_err", mv.move_err, 0);
        btn_reset = 1'b0;
        @(negedge clk_100mhz);

        // First move 20 -> 80, then rejects from 80.
        run_move(80, -1, 1'b0, 1'b0);
        run_move(80, -1, 1'b0, 1'b0);
        run_move(680, -1, 1'b0, 1'b0);
        run_move(90, -1, 1'b1, 1'b0);

        // Request held after turn_done must not retrigger.
        for (int i = 0; i < 10; i++) begin
            frame_tick = (i % 3 == 0);
            @(negedge clk_100mhz);
            frame_tick = 1'b0;
            check("hold_busy", mv.busy, 0);
            check("hold_pos", pos_x, 80);
            check("hold_done", mv.turn_done, 0);
        end
        mv.move_start = 1'b0;
        @(negedge clk_100mhz);
        run_move(140, -1, 1'b0, 1'b0);

        // Back home, then 20 -> 80 -> 260 (request dropped mid-move).
        btn_reset = 1'b1;
        @(negedge clk_100mhz);
        check("home_pos", pos_x, START_X);
        btn_reset = 1'b0;
        model_pos = START_X;
        @(negedge clk_100mhz);
        run_move(80, -1, 1'b0, 1'b1);
        run_move(260, 45, 1'b0, 1'b0);

        // Reset asserted at tick 10 of a move.
        mv.move_start = 1'b1;
        mv.target_x   = 10'd380;
        @(negedge clk_100mhz);
        mv.move_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100mhz);
            tick();
        end
        check("abort_pre_pos", pos_x, 280);
        #2 btn_reset = 1'b1;
        #1;
        check("abort_pos", pos_x, START_X);
        check("abort_tile", tile_idx, 0);
        check("abort_hop", hop_y, 0);
        check("abort_busy", mv.busy, 0);
        @(negedge clk_100mhz);
        btn_reset = 1'b0;
        model_pos = START_X;
        pulses    = 0;
        repeat (40) begin
            frame_tick = 1'($urandom_range(0, 1));
            @(negedge clk_100mhz);
            frame_tick = 1'b0;
            if (mv.turn_done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_idle_busy", mv.busy, 0);
        check("abort_idle_pos", pos_x, START_X);

        // Random requests, mostly legal, from wherever the token stands.
        repeat (12) begin
            r = int'($urandom_range(0, 3));
            if (r == 0 || model_pos >= MAX_X) begin
                tgt = int'($urandom_range(0, 1023));
            end else begin
                rem = (MAX_X - model_pos) / SP;
                if (rem > 3) rem = 3;
                tgt = model_pos + SP * int'($urandom_range(1, rem));
            end
            run_move(tgt, int'($urandom_range(0, 40)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
